uart_mem_master: RTL and testbench

- Host-side initiator for the UART memory-access byte protocol; the far end of the UART is the on-chip UART-to-memory bridge.
- Converts a simple memory request (req/we/addr/wdata) into the command, address and data byte sequence.
- Checks the bridge's echoes and collects read data.
- Connects to the existing `uart` core through byte-level ports. Used in FPGA host adapters and in the chip-level bench as the bus-functional master.

---
 rtl/uart_mem_pkg.sv | 42 ++++
 rtl/uart_mem_master.sv | 167 ++++++++++++++++
 tb/tb_uart_mem_master.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_mem_pkg.sv
// Shared constants and state encoding for the UART memory-access byte protocol.
// Imported by both the host-side master and the on-chip bridge.
package uart_mem_pkg;

    localparam logic [7:0] PKT_ALIVE     = 8'h20;
    localparam logic [7:0] PKT_WRITE_CMD = 8'h41;
    localparam logic [7:0] PKT_READ_CMD  = 8'h42;
    localparam logic [7:0] PKT_ADR       = 8'h60;

    localparam logic [2:0] STEP_CMD  = 3'd0;
    localparam logic [2:0] STEP_HEAD = 3'd1;
    localparam logic [2:0] STEP_TAIL = 3'd2;
    localparam logic [2:0] STEP_LAST = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TX,
        ST_WAIT_ECHO,
        ST_RX_DATA,
        ST_FINISH
    } mem_state_t;

    // Byte carried by a given step: 0 cmd, 1 head, 2 tail, 3..6 data MSB first.
    function automatic logic [7:0] step_byte(input logic        we,
                                             input logic [11:0] addr,
                                             input logic [31:0] data,
                                             input logic [2:0]  step);
        logic [7:0] b;
        case (step)
            3'd0:    b = we ? PKT_WRITE_CMD : PKT_READ_CMD;
            3'd1:    b = PKT_ADR | {4'h0, addr[11:8]};
            3'd2:    b = addr[7:0];
            3'd3:    b = data[31:24];
            3'd4:    b = data[23:16];
            3'd5:    b = data[15:8];
            3'd6:    b = data[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_mem_master.sv
// Host-side initiator for the UART memory-access protocol: serialises a word
// request into cmd/head/tail/data bytes, checks bridge echoes and collects read data.
module uart_mem_master
    import uart_mem_pkg::*;
#(
    parameter int ADDR_WIDTH     = 12,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    output logic                  gnt_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [31:0]           rdata_o,
    output logic                  busy_o,
    output logic                  tx_start_o,
    output logic [7:0]            tx_byte_o,
    input  logic                  tx_busy_i,
    input  logic                  rx_valid_i,
    input  logic [7:0]            rx_byte_i,
    input  logic                  rx_error_i
);

    localparam int              TW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    mem_state_t     state;
    logic [2:0]     step;
    logic [1:0]     rx_cnt;
    logic [TW-1:0]  tmo;
    logic           we_q;
    logic [11:0]    addr_q;
    logic [31:0]    wdata_q;
    logic [23:0]    shift_q;

    logic [7:0]     cur_byte;
    logic           echo_ok;
    logic           tmo_hit;

    // The head echo is only checked on its fixed tag bits.
    always_comb begin
        cur_byte = step_byte(we_q, addr_q, wdata_q, step);
        echo_ok  = (step == STEP_HEAD) ? (rx_byte_i[7:5] == PKT_ADR[7:5])
                                       : (rx_byte_i == cur_byte);
        tmo_hit  = (tmo == TMO_LAST);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            step       <= '0;
            rx_cnt     <= '0;
            tmo        <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            shift_q    <= '0;
            gnt_o      <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            rdata_o    <= '0;
            busy_o     <= 1'b0;
            tx_start_o <= 1'b0;
            tx_byte_o  <= '0;
        end else begin
            gnt_o  <= 1'b0;
            done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_i) begin
                        gnt_o   <= 1'b1;
                        busy_o  <= 1'b1;
                        we_q    <= we_i;
                        addr_q  <= 12'(addr_i);
                        wdata_q <= wdata_i;
                        step    <= STEP_CMD;
                        state   <= ST_TX;
                    end
                end

                ST_TX: begin
                    if (!tx_start_o) begin
                        if (!tx_busy_i) begin
                            tx_byte_o  <= cur_byte;
                            tx_start_o <= 1'b1;
                        end
                    end else if (tx_busy_i) begin
                        tx_start_o <= 1'b0;
                        tmo        <= '0;
                        if (!we_q && step == STEP_TAIL) begin
                            rx_cnt <= '0;
                            state  <= ST_RX_DATA;
                        end else begin
                            state  <= ST_WAIT_ECHO;
                        end
                    end
                end

                ST_WAIT_ECHO: begin
                    if (rx_valid_i) begin
                        tmo <= '0;
                        if (rx_error_i || (!echo_ok &&
                                !(step == STEP_CMD && rx_byte_i == PKT_ALIVE))) begin
                            done_o <= 1'b1;
                            err_o  <= 1'b1;
                            state  <= ST_FINISH;
                        end else if (step == STEP_CMD && rx_byte_i == PKT_ALIVE) begin
                            state  <= ST_WAIT_ECHO;
                        end else if (we_q && step == STEP_LAST) begin
                            done_o <= 1'b1;
                            err_o  <= 1'b0;
                            state  <= ST_FINISH;
                        end else begin
                            step   <= step + 3'd1;
                            state  <= ST_TX;
                        end
                    end else if (tmo_hit) begin
                        done_o <= 1'b1;
                        err_o  <= 1'b1;
                        state  <= ST_FINISH;
                    end else begin
                        tmo <= tmo + TW'(1);
                    end
                end

                ST_RX_DATA: begin
                    if (rx_valid_i) begin
                        tmo <= '0;
                        if (rx_error_i) begin
                            done_o <= 1'b1;
                            err_o  <= 1'b1;
                            state  <= ST_FINISH;
                        end else begin
                            shift_q <= {shift_q[15:0], rx_byte_i};
                            rx_cnt  <= rx_cnt + 2'd1;
                            if (rx_cnt == 2'd3) begin
                                rdata_o <= {shift_q, rx_byte_i};
                                done_o  <= 1'b1;
                                err_o   <= 1'b0;
                                state   <= ST_FINISH;
                            end
                        end
                    end else if (tmo_hit) begin
                        done_o <= 1'b1;
                        err_o  <= 1'b1;
                        state  <= ST_FINISH;
                    end else begin
                        tmo <= tmo + TW'(1);
                    end
                end

                ST_FINISH: begin
                    err_o  <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_mem_master.sv
// Randomised scoreboard bench for uart_mem_master with a behavioural UART/bridge
// model; expectations come from the byte-protocol rules, checked by a monitor.
module tb_uart_mem_master;
    import uart_mem_pkg::*;

    localparam int AW  = 12;
    localparam int TMO = 50;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          req_i, we_i;
    logic [AW-1:0] addr_i;
    logic [31:0]   wdata_i;
    logic          gnt_o, done_o, err_o, busy_o, tx_start_o;
    logic [31:0]   rdata_o;
    logic [7:0]    tx_byte_o;
    logic          tx_busy_i, rx_valid_i, rx_error_i;
    logic [7:0]    rx_byte_i;

    always #5 clk_i = ~clk_i;

    uart_mem_master #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .done_o(done_o),
        .err_o(err_o), .rdata_o(rdata_o), .busy_o(busy_o),
        .tx_start_o(tx_start_o), .tx_byte_o(tx_byte_o), .tx_busy_i(tx_busy_i),
        .rx_valid_i(rx_valid_i), .rx_byte_i(rx_byte_i), .rx_error_i(rx_error_i)
    );

    typedef struct {
        bit          err;
        bit          tmo;
        bit          rd;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  exp_tx[$];
    int          checks = 0, failures = 0;
    int          n_done = 0, cyc = 0, t_fall = 0, gnt_cnt = 0;
    bit          prev_start = 0, prev_busy = 0;
    logic [31:0] model_rdata = '0;

    // Bridge model configuration for the current transaction.
    bit          cfg_we = 1'b1, cfg_alive = 1'b0;
    int          cfg_corrupt = -1, cfg_silent = -1, cfg_err = -1;
    logic [31:0] cfg_rdata = '0;
    int          alive_req = 0, alive_done = 0;
    int          tx_idx = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // ---------------- UART + bridge behavioural model ----------------
    task automatic wait_ticks(input int n);
        for (int i = 0; i < n && !rst_i; i++) @(negedge clk_i);
    endtask

    task automatic send_rx(input logic [7:0] b, input bit e);
        wait_ticks($urandom_range(1, 3));
        if (rst_i) return;
        rx_byte_i  = b;
        rx_error_i = e;
        rx_valid_i = 1'b1;
        @(negedge clk_i);
        rx_valid_i = 1'b0;
        rx_error_i = 1'b0;
    endtask

    task automatic respond(input int idx, input logic [7:0] b);
        if (idx == cfg_silent) return;
        if (idx == 0 && cfg_alive) send_rx(8'h20, 1'b0);
        if (!cfg_we && idx == 2) begin
            for (int k = 0; k < 4; k++) begin
                send_rx(cfg_rdata[31-8*k -: 8], k == cfg_err);
                if (k == cfg_err) break;
            end
        end else begin
            send_rx((idx == cfg_corrupt) ? (b ^ ((idx == 1) ? 8'h20 : 8'h01)) : b, 1'b0);
        end
    endtask

    initial begin : bridge_model
        logic [7:0] b;
        tx_busy_i = 1'b0; rx_valid_i = 1'b0; rx_byte_i = '0; rx_error_i = 1'b0;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                tx_busy_i = 1'b0; rx_valid_i = 1'b0; rx_error_i = 1'b0; tx_idx = 0;
            end else begin
                if (gnt_o) tx_idx = 0;
                if (alive_req != alive_done) begin
                    alive_done = alive_req;
                    send_rx(8'h20, 1'b0);
                end else if (tx_start_o && !tx_busy_i) begin
                    b = tx_byte_o;
                    tx_busy_i = 1'b1;
                    wait_ticks($urandom_range(2, 5));
                    tx_busy_i = 1'b0;
                    if (!rst_i) respond(tx_idx, b);
                    tx_idx++;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_i);
            cyc++;
            if (rst_i) begin
                model_rdata = '0; gnt_cnt = 0; prev_start = 0; prev_busy = 0;
            end else begin
                if (tx_start_o && !prev_start) begin
                    if (exp_tx.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL tx_extra actual=%h required=none", tx_byte_o);
                    end else begin
                        check("tx_byte", tx_byte_o, exp_tx.pop_front());
                    end
                end
                if (!tx_start_o && prev_start) t_fall = cyc;
                if (gnt_o) begin
                    gnt_cnt++;
                    check("gnt_while_busy", prev_busy, 0);
                end
                if (done_o) begin
                    n_done++;
                    if (exp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL done_extra actual=1 required=0");
                    end else begin
                        e = exp_q.pop_front();
                        check("err", err_o, e.err);
                        check("busy_at_done", busy_o, 1);
                        check("gnt_count", gnt_cnt, 1);
                        check("tx_missing", exp_tx.size(), 0);
                        if (e.tmo) check("tmo_latency", cyc - t_fall, TMO);
                        if (e.rd && !e.err) model_rdata = e.rdata;
                        check("rdata", rdata_o, model_rdata);
                    end
                    gnt_cnt = 0;
                end
                prev_start = tx_start_o;
                prev_busy  = busy_o;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_txn(input bit we, input logic [11:0] a, input logic [31:0] d,
                          input int corrupt, input int silent, input int err_idx,
                          input bit alive, input bit idle_alive);
        logic [7:0] seq[7];
        int         n, d0;
        exp_t       e;
        seq[0] = we ? 8'h41 : 8'h42;
        seq[1] = 8'h60 | {4'h0, a[11:8]};
        seq[2] = a[7:0];
        seq[3] = d[31:24]; seq[4] = d[23:16]; seq[5] = d[15:8]; seq[6] = d[7:0];
        n = we ? 7 : 3;
        if (corrupt >= 0) n = corrupt + 1;
        else if (silent >= 0) n = silent + 1;
        for (int i = 0; i < n; i++) exp_tx.push_back(seq[i]);
        e.err   = (corrupt >= 0) || (silent >= 0) || (!we && err_idx >= 0);
        e.tmo   = (silent >= 0);
        e.rd    = !we;
        e.rdata = d;
        exp_q.push_back(e);

        cfg_we = we; cfg_rdata = d; cfg_alive = alive;
        cfg_corrupt = corrupt; cfg_silent = silent; cfg_err = err_idx;
        if (idle_alive) begin
            alive_req++;
            repeat (8) @(negedge clk_i);
        end

        d0 = n_done;
        @(negedge clk_i);
        req_i = 1'b1; we_i = we; addr_i = a; wdata_i = we ? d : $urandom;
        for (int i = 0; i < 20 && !gnt_o; i++) @(negedge clk_i);
        if (!gnt_o) begin
            checks++; failures++;
            $display("FAIL gnt_timeout actual=0 required=1");
        end
        req_i = 1'b0;
        for (int i = 0; i < 800 && n_done == d0; i++) @(negedge clk_i);
        if (n_done == d0) begin
            checks++; failures++;
            $display("FAIL done_timeout actual=0 required=1");
            exp_q.delete();
            exp_tx.delete();
        end
        repeat (3) @(negedge clk_i);
    endtask

    task automatic check_outputs_clear(input string tag);
        check({tag, "_gnt"}, gnt_o, 0);
        check({tag, "_done"}, done_o, 0);
        check({tag, "_err"}, err_o, 0);
        check({tag, "_rdata"}, rdata_o, 0);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_tx_start"}, tx_start_o, 0);
        check({tag, "_tx_byte"}, tx_byte_o, 0);
        check({tag, "_state"}, 32'(dut.state), 32'(ST_IDLE));
    endtask

    initial begin : main
        rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
        repeat (2) @(negedge clk_i);
        check_outputs_clear("reset");
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);

        do_txn(1, 12'h3A5, 32'hDEADBEEF, -1, -1, -1, 0, 0);
        do_txn(0, 12'h012, 32'h12345678, -1, -1, -1, 0, 0);
        do_txn(1, 12'hF0C, 32'h01020304,  -1, -1, -1, 1, 1);
        do_txn(0, 12'h7E1, 32'h20AB2011,  -1, -1, -1, 1, 1);
        do_txn(1, 12'h3A5, 32'hCAFEF00D,   2, -1, -1, 0, 0);
        do_txn(0, 12'h155, 32'h55AA55AA,   1, -1, -1, 0, 0);
        do_txn(1, 12'h0AB, 32'h11223344,  -1,  0, -1, 0, 0);
        do_txn(0, 12'h0CD, 32'h99887766,  -1,  2, -1, 0, 0);
        do_txn(0, 12'h222, 32'hA1B2C3D4,  -1, -1,  2, 0, 0);
        do_txn(1, 12'h333, 32'h0BADF00D,  -1, -1, -1, 0, 0);

        for (int t = 0; t < 16; t++)
            do_txn(1'($urandom_range(0, 1)), 12'($urandom), $urandom,
                   -1, -1, -1, ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));

        // Held request then reset in the middle of the data bytes.
        exp_tx.push_back(8'h41); exp_tx.push_back(8'h64); exp_tx.push_back(8'h56);
        exp_tx.push_back(8'h89); exp_tx.push_back(8'hAB);
        exp_tx.push_back(8'hCD); exp_tx.push_back(8'hEF);
        cfg_we = 1'b1; cfg_alive = 1'b0; cfg_corrupt = -1; cfg_silent = -1; cfg_err = -1;
        @(negedge clk_i);
        req_i = 1'b1; we_i = 1'b1; addr_i = 12'h456; wdata_i = 32'h89ABCDEF;
        for (int i = 0; i < 600 && exp_tx.size() > 3; i++) @(negedge clk_i);
        check("reset_reached_data", (exp_tx.size() <= 3), 1);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check_outputs_clear("midreset");
        req_i = 1'b0;
        repeat (3) @(negedge clk_i);
        exp_tx.delete();
        rst_i = 1'b0;
        repeat (3) @(negedge clk_i);

        do_txn(0, 12'h0F0, 32'h5A5AC3C3, -1, -1, -1, 0, 0);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
